sub_seq: RTL and testbench
==========================

Name: sub_seq

Overview:
Multi-cycle unsigned subtractor that computes a - b, Chunk bits per cycle, using a ripple-borrow chain. It is the inverse-direction companion to the combinational ripple-carry adder in the arithmetic library. Wide operands get a short per-cycle critical path. Operands enter and results leave through valid/ready handshakes, so the block sits between pipeline stages in the arithmetic datapath.

Parameters:
Bits, 64, operand and result width.
Chunk, 16, bits subtracted per cycle. Bits % Chunk == 0 and Chunk >= 1 are required; elaboration fails otherwise.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
in_valid  input  1  operands a, b are valid.
in_ready  output  1  block can accept operands.
a  input  Bits  minuend (unsigned).
b  input  Bits  subtrahend (unsigned).
out_valid  output  1  diff and borrow are valid.
out_ready  input  1  consumer accepts the result.
diff  output  Bits  (a - b) mod 2^Bits.
borrow  output  1  1 iff a < b (unsigned).

Behaviour:
- Steps = Bits/Chunk. Step counter width is max(1, clog2(Steps)).
- Reset (reset==0, asynchronous):
  - State goes to IDLE.
  - diff=0, borrow=0, out_valid=0, internal borrow=0, counter=0.
  - in_ready=1.
  - An operation in flight is abandoned, with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at an edge: latch a and b, clear the internal borrow and the counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle with k = counter: diff[k*Chunk +: Chunk] <= a_k - b_k - bin, and bin <= borrow-out of that chunk.
  - Counter increments each cycle.
  - After chunk Steps-1: borrow <= final borrow-out, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - diff and borrow are held stable while out_ready=0.
  - On out_ready=1 at an edge: go to IDLE and clear out_valid.
- Latency: operands accepted at edge T; out_valid is high from edge T+Steps.
- Minimum initiation interval is Steps+2 cycles: Steps in RUN, one in DONE, one in IDLE.
- in_valid is ignored outside IDLE, and a/b are don't-care outside the accept edge. The latched copies are used throughout, so the source may change a/b after the handshake.
- Steps==1 degenerates to a single RUN cycle; behaviour is otherwise unchanged.
- Chunk arithmetic is a Chunk+1-bit subtract: {bout, d} = {1'b0,a_k} - {1'b0,b_k} - bin.
- Simultaneous out_ready and in_valid in DONE: only the result handshake completes. The new operand is taken in IDLE on the next edge.
- Reset asserted during DONE drops out_valid immediately (asynchronously); the result is lost.

Decomposition:
- Shared arithmetic package (sub_seq_pkg) holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
  - the Steps computation,
  - the counter-width helper function.
- One sub-module, sub_chunk: a combinational Chunk-bit ripple-borrow subtractor (inputs a, b, bin; outputs d, bout), built from a full-subtractor cell per bit to mirror the adder structure. sub_seq instantiates one sub_chunk and muxes chunk k into it.

Test Plan:
- Bits=64, Chunk=16; a=100, b=58 -> diff=42, borrow=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1; the borrow propagates through all 4 chunks.
- a=0x0001_0000_0000_0000, b=1 -> diff=0x0000_FFFF_FFFF_FFFF, borrow=0 (cross-chunk borrow stops in chunk 3).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while toggling in_valid with new a/b -> diff/borrow stable, in_ready=0, no new operand accepted. Release -> IDLE, then the next operand is accepted and computed correctly.
- Drive reset=0 asynchronously mid-RUN (counter=2) -> out_valid=0, in_ready=1, diff=0 immediately. After release, a=7, b=7 -> diff=0, borrow=0.
- Bits=8, Chunk=8 (Steps=1); a=3, b=5 -> diff=0xFE, borrow=1, out_valid one cycle after accept. Back-to-back ops with out_ready=1 and in_valid=1 show one accept every 3 cycles.

Source files
------------

// File: rtl/sub_seq_pkg.sv
// Shared definitions for the multi-cycle ripple-borrow subtractor:
// FSM encoding and the step / counter-width helpers.
package sub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int steps_f(input int bits, input int chunk);
        return (chunk > 0) ? (bits / chunk) : 1;
    endfunction

    function automatic int cnt_width_f(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational Chunk-bit ripple-borrow subtractor built from one
// full-subtractor cell per bit.
module sub_chunk #(
    parameter int Chunk = 16
) (
    input  logic [Chunk-1:0] a,
    input  logic [Chunk-1:0] b,
    input  logic             bin,
    output logic [Chunk-1:0] d,
    output logic             bout
);

    logic [Chunk:0] br_s;

    assign br_s[0] = bin;

    for (genvar i = 0; i < Chunk; i++) begin : g_fs
        assign d[i]      = a[i] ^ b[i] ^ br_s[i];
        assign br_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br_s[i]);
    end

    assign bout = br_s[Chunk];

endmodule

// File: rtl/sub_seq.sv
// Multi-cycle unsigned subtractor: a - b computed Chunk bits per cycle,
// with valid/ready handshakes on both the operand and result sides.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int Bits  = 64,
    parameter int Chunk = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Bits-1:0] a,
    input  logic [Bits-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Bits-1:0] diff,
    output logic            borrow
);

    localparam int Steps = steps_f(Bits, Chunk);
    localparam int CntW  = cnt_width_f(Steps);
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    if (Chunk < 1 || (Bits % Chunk) != 0) begin : g_bad_params
        $fatal(1, "sub_seq: Bits must be a non-zero multiple of Chunk");
    end

    state_e                        state_q, state_d;
    logic [Steps-1:0][Chunk-1:0]   a_q, a_d;
    logic [Steps-1:0][Chunk-1:0]   b_q, b_d;
    logic [Steps-1:0][Chunk-1:0]   diff_q, diff_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic                          bin_q, bin_d;
    logic                          borrow_q, borrow_d;
    logic                          out_valid_q, out_valid_d;
    logic                          in_ready_q, in_ready_d;

    logic [Chunk-1:0]              a_k_s;
    logic [Chunk-1:0]              b_k_s;
    logic [Chunk-1:0]              d_s;
    logic                          bout_s;

    // The single chunk subtractor is time-shared across all steps.
    assign a_k_s = a_q[cnt_q];
    assign b_k_s = b_q[cnt_q];

    sub_chunk #(
        .Chunk (Chunk)
    ) u_chunk (
        .a    (a_k_s),
        .b    (b_k_s),
        .bin  (bin_q),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next-state and next-output computation for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    bin_d      = 1'b0;
                    cnt_d      = {CntW{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                diff_d[cnt_q] = d_s;
                bin_d         = bout_s;
                cnt_d         = cnt_q + CntW'(1'b1);
                if (cnt_q == LastCnt) begin
                    borrow_d    = bout_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // A pending in_valid is not taken here; it waits for IDLE.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = {CntW{1'b0}};
                bin_d       = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            cnt_q       <= {CntW{1'b0}};
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_sub_seq.sv
// Randomized self-checking bench for sub_seq (64/16 and 8/8 configurations)
// against a plain-arithmetic reference model.
module tb_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, borrow;
    logic [63:0] a, b, diff;

    logic        rst8_n;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
    logic [7:0]  a8, b8, diff8;

    int n_checks = 0;
    int n_errors = 0;

    sub_seq #(.Bits(64), .Chunk(16)) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    sub_seq #(.Bits(8), .Chunk(8)) u_dut8 (
        .clk       (clk),
        .reset     (rst8_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // One full transaction on the 64-bit instance; entered and left on a negedge.
    task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input int hold);
        logic [63:0] ed;
        logic        eb;
        int          lat;
        ed = av - bv;
        eb = (av < bv);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = rand64();
        b        = rand64();
        check("run_in_ready", 64'(in_ready), 64'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
        check("diff", diff, ed);
        check("borrow", 64'(borrow), 64'(eb));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = rand64();
            b        = rand64();
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_diff", diff, ed);
            check("hold_borrow", 64'(borrow), 64'(eb));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [7:0]  av8, bv8;
        logic [8:0]  exq[$];
        logic [8:0]  e9;

        rst_n      = 1'b0;
        rst8_n     = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = 64'd0;
        b          = 64'd0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        a8         = 8'd0;
        b8         = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rst8_n = 1'b1;

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", diff, 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);

        do_op(64'd100, 64'd58, 0);
        do_op(64'd0, 64'd1, 0);
        do_op(64'h0001_0000_0000_0000, 64'd1, 0);
        do_op(rand64(), rand64(), 5);
        for (int i = 0; i < 8; i++) begin
            ra = rand64();
            rb = rand64();
            if (i == 2) rb = ra;
            if (i == 3) rb = {48'd0, ra[15:0]};
            do_op(ra, rb, $urandom_range(0, 3));
        end

        // Abort an operation while the counter sits at 2.
        in_valid = 1'b1;
        a        = rand64();
        b        = rand64();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_diff", diff, 64'd0);
        check("abort_borrow", 64'(borrow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(64'd7, 64'd7, 0);

        // Single-step instance driven back to back: one accept every 3 cycles.
        for (int c = 0; c < 15; c++) begin
            check("b2b_in_ready", 64'(in_ready8), 64'((c % 3) == 0));
            check("b2b_out_valid", 64'(out_valid8), 64'((c % 3) == 2));
            if ((c % 3) == 2) begin
                e9 = exq.pop_front();
                check("b2b_diff", 64'(diff8), 64'(e9[7:0]));
                check("b2b_borrow", 64'(borrow8), 64'(e9[8]));
            end
            if (c == 0) begin
                av8 = 8'd3;
                bv8 = 8'd5;
            end else begin
                av8 = 8'($urandom());
                bv8 = 8'($urandom());
            end
            if ((c % 3) == 0) exq.push_back({(av8 < bv8), 8'(av8 - bv8)});
            a8         = av8;
            b8         = bv8;
            in_valid8  = 1'b1;
            out_ready8 = 1'b1;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
